// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces an active-low button into press/release/hold events and a press count
module btn_debounce #(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd240000,
  parameter logic [23:0] HOLD_CYCLES     = 24'd12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       hold_pulse,
  output logic       held,
  output logic [7:0] press_count
);
  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] PRESS_WAIT   = 3'd1;
  localparam logic [2:0] PRESSED      = 3'd2;
  localparam logic [2:0] HELD         = 3'd3;
  localparam logic [2:0] RELEASE_WAIT = 3'd4;
  logic        s1, s2, btn_s, db_done, hold_done, press_go;
  logic [2:0]  state, state_nx;
  logic [23:0] db_cnt, db_nx, hold_cnt, hold_nx;
  assign btn_s     = ~s2;
  assign db_done   = db_cnt == DEBOUNCE_CYCLES - 24'd1;
  assign hold_done = hold_cnt == HOLD_CYCLES - 24'd1;
  assign press_go  = state == PRESS_WAIT && state_nx == PRESSED;
  always_comb begin
    state_nx = state;
    db_nx    = db_cnt;
    hold_nx  = hold_cnt;
    case (state)
      IDLE:
        if (btn_s) begin
          state_nx = PRESS_WAIT;
          db_nx    = '0;
        end
      PRESS_WAIT:
        if (!btn_s) state_nx = IDLE;
        else if (db_done) begin
          state_nx = PRESSED;
          hold_nx  = '0;
        end else db_nx = db_cnt + 24'd1;
      PRESSED:
        if (!btn_s) begin
          state_nx = RELEASE_WAIT;
          db_nx    = '0;
        end else if (hold_done) state_nx = HELD;
        else hold_nx = hold_cnt + 24'd1;
      HELD:
        if (!btn_s) begin
          state_nx = RELEASE_WAIT;
          db_nx    = '0;
        end
      RELEASE_WAIT:
        if (btn_s) state_nx = held ? HELD : PRESSED;
        else if (db_done) state_nx = IDLE;
        else db_nx = db_cnt + 24'd1;
      default: state_nx = IDLE;
    endcase
  end
  // outputs are registered from the next state so nothing combinational reaches them from btn_n
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      pressed       <= 1'b0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      s1            <= btn_n;
      s2            <= s1;
      state         <= state_nx;
      db_cnt        <= db_nx;
      hold_cnt      <= hold_nx;
      pressed       <= state_nx == PRESSED || state_nx == HELD || state_nx == RELEASE_WAIT;
      held          <= state_nx == HELD || (state_nx == RELEASE_WAIT && held);
      press_pulse   <= press_go;
      release_pulse <= state == RELEASE_WAIT && state_nx == IDLE;
      hold_pulse    <= state == PRESSED && state_nx == HELD;
      press_count   <= press_count + {7'd0, press_go};
    end
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: two instances (4/10 and 1/1) driven together, checked per cycle against a run-length model
module tb_btn_debounce;
  localparam int D0 = 4, H0 = 10, D1 = 1, H1 = 1;
  typedef struct packed {
    logic       pressed;
    logic       held;
    logic       pp;
    logic       rp;
    logic       hp;
    logic [7:0] cnt;
  } obs_t;
  typedef obs_t [1:0] pair_t;
  logic       clk = 1'b0, rst = 1'b0, btn_n = 1'b1;
  logic [1:0] pressed, press_pulse, release_pulse, hold_pulse, held;
  logic [7:0] press_count [2];
  obs_t       act [2];
  pair_t      q [$];
  int         errors = 0, checks = 0, cyc = 0;
  bit         m1 [2], m2 [2], lvl [2], hd [2];
  int         run [2], hc [2];
  logic [7:0] cnt [2];
  always #5 clk = ~clk;
  btn_debounce #(.DEBOUNCE_CYCLES(24'(D0)), .HOLD_CYCLES(24'(H0))) dut0 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(pressed[0]), .press_pulse(press_pulse[0]),
    .release_pulse(release_pulse[0]), .hold_pulse(hold_pulse[0]), .held(held[0]), .press_count(press_count[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(24'(D1)), .HOLD_CYCLES(24'(H1))) dut1 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(pressed[1]), .press_pulse(press_pulse[1]),
    .release_pulse(release_pulse[1]), .hold_pulse(hold_pulse[1]), .held(held[1]), .press_count(press_count[1])
  );
  assign act[0] = {pressed[0], held[0], press_pulse[0], release_pulse[0], hold_pulse[0], press_count[0]};
  assign act[1] = {pressed[1], held[1], press_pulse[1], release_pulse[1], hold_pulse[1], press_count[1]};
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m1[i] = 1; m2[i] = 1; lvl[i] = 0; hd[i] = 0; run[i] = 0; hc[i] = 0; cnt[i] = '0;
    end
  endtask
  // a level change is accepted after debounce+1 consecutive disagreeing samples;
  // hold time accrues only on samples that agree with an accepted press following an agreeing one
  task automatic model_step(input int i, output obs_t o);
    bit s, pp, rp, hp;
    int dc, hcy;
    dc  = (i == 0) ? D0 : D1;
    hcy = (i == 0) ? H0 : H1;
    s = !m2[i];
    m2[i] = m1[i];
    m1[i] = btn_n;
    pp = 0; rp = 0; hp = 0;
    if (s != lvl[i]) begin
      run[i]++;
      if (run[i] == dc + 1) begin
        lvl[i] = s; run[i] = 0; hd[i] = 0;
        if (s) begin pp = 1; cnt[i]++; hc[i] = 0; end
        else rp = 1;
      end
    end else begin
      if (lvl[i] && !hd[i] && run[i] == 0) begin
        if (hc[i] == hcy - 1) begin hd[i] = 1; hp = 1; end
        else hc[i]++;
      end
      run[i] = 0;
    end
    o = {lvl[i], hd[i], pp, rp, hp, cnt[i]};
  endtask
  always @(posedge clk) begin
    pair_t e;
    if (rst) begin
      model_reset();
      e = '0;
    end else begin
      model_step(0, e[0]);
      model_step(1, e[1]);
    end
    q.push_back(e);
  end
  // asynchronous reset clears the outputs before the next sample point
  always @(posedge rst) begin
    model_reset();
    if (q.size() > 0) q[q.size() - 1] = '0;
  end
  always @(negedge clk) begin
    pair_t e;
    cyc++;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL underflow cyc=%0d: no expected entry", cyc);
    end else begin
      e = q.pop_front();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act[i] !== e[i]) begin
          errors++;
          $display("FAIL outputs inst%0d cyc=%0d: got pressed=%b held=%b pp=%b rp=%b hp=%b cnt=%0d, expected pressed=%b held=%b pp=%b rp=%b hp=%b cnt=%0d",
                   i, cyc, act[i].pressed, act[i].held, act[i].pp, act[i].rp, act[i].hp, act[i].cnt,
                   e[i].pressed, e[i].held, e[i].pp, e[i].rp, e[i].hp, e[i].cnt);
        end
        checks++;
        if ($countones({act[i].pp, act[i].rp, act[i].hp}) > 1) begin
          errors++;
          $display("FAIL pulse_overlap inst%0d cyc=%0d: got pp=%b rp=%b hp=%b, expected at most one high",
                   i, cyc, act[i].pp, act[i].rp, act[i].hp);
        end
      end
    end
  end
  task automatic drive(input bit b, input int n);
    btn_n = b;
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    drive(1, 5);
    drive(0, 30);
    drive(1, 30);
    repeat (5) begin
      drive(0, 3);
      drive(1, 1);
    end
    drive(1, 10);
    drive(0, 12);
    drive(1, 2);
    drive(0, 30);
    drive(1, 30);
    repeat (256) begin
      drive(0, 9);
      drive(1, 9);
    end
    drive(0, 25);
    rst = 1'b1;
    drive(0, 3);
    rst = 1'b0;
    drive(0, 20);
    drive(1, 20);
    repeat (300) drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
    drive(1, 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
